// File: rtl/io_controller_if.sv
// UART-side ready/valid handshakes of the memory-mapped IO controller.
// The master side is the controller; the slave side is the UART.
interface io_controller_if;
   logic [7:0] uart_tx_data;
   logic       uart_tx_valid;
   logic       uart_tx_ready;
   logic [7:0] uart_rx_data;
   logic       uart_rx_valid;
   logic       uart_rx_ready;

   modport master (
      output uart_tx_data, uart_tx_valid, uart_rx_ready,
      input  uart_tx_ready, uart_rx_data, uart_rx_valid
   );

   modport slave (
      input  uart_tx_data, uart_tx_valid, uart_rx_ready,
      output uart_tx_ready, uart_rx_data, uart_rx_valid
   );
endinterface

// File: rtl/io_controller.sv
// Memory-mapped IO block for the pipeline's memory stage.
// It provides a status register, an RX byte FIFO, a single-byte TX port, and cycle and retired-instruction counters.
module io_controller #(
   parameter int RX_DEPTH = 4
) (
   input  logic            Clock,
   input  logic            Reset_n,
   input  logic [31:0]     addr,
   input  logic [3:0]      io_trans,
   input  logic            io_recv,
   input  logic [31:0]     wdata,
   input  logic            haz_ena,
   input  logic            inst_retire,
   output logic [31:0]     io_rdata,
   io_controller_if.master uart
);

   localparam int PW = $clog2(RX_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(RX_DEPTH);

   localparam logic [7:0] OFF_STATUS = 8'h00;
   localparam logic [7:0] OFF_RXDATA = 8'h04;
   localparam logic [7:0] OFF_TXDATA = 8'h08;
   localparam logic [7:0] OFF_CYCLE  = 8'h10;
   localparam logic [7:0] OFF_RETIRE = 8'h14;
   localparam logic [7:0] OFF_CLEAR  = 8'h18;

   typedef enum logic [0:0] {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_e;

   tx_state_e         state_q, state_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic [31:0]       io_rdata_q, io_rdata_d;
   logic [31:0]       cycle_q, cycle_d;
   logic [31:0]       retired_q, retired_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [7:0]        rx_mem_q [RX_DEPTH];
   logic [7:0]        rx_mem_d [RX_DEPTH];

   logic       sel_s, load_s, store_s, push_s, pop_s, tx_start_s, clear_s, nonempty_s;
   logic [7:0] off_s;
   logic       unused_bits_s;

   assign unused_bits_s = ^{addr[27:8], wdata[31:8]};

   // Stall (haz_ena low) and out-of-window addresses both suppress every bus side effect.
   always_comb begin
      sel_s      = (addr[31:28] == 4'h8);
      off_s      = addr[7:0];
      load_s     = io_recv & haz_ena & sel_s;
      store_s    = (|io_trans) & haz_ena & sel_s;
      nonempty_s = (count_q != {CW{1'b0}});
      push_s     = uart.uart_rx_valid & (count_q != FULL);
      pop_s      = load_s & (off_s == OFF_RXDATA) & nonempty_s;
      tx_start_s = store_s & (off_s == OFF_TXDATA) & io_trans[0];
      clear_s    = store_s & (off_s == OFF_CLEAR);
   end

   // RX FIFO next state; power-of-two depth lets the pointers wrap by overflow.
   always_comb begin
      rx_mem_d = rx_mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_s) begin
         rx_mem_d[wr_ptr_q] = uart.uart_rx_data;
         wr_ptr_d           = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
   end

   // Load data is captured only when a load is accepted and held otherwise.
   always_comb begin
      io_rdata_d = io_rdata_q;
      if (load_s) begin
         case (off_s)
            OFF_STATUS: io_rdata_d = {30'b0, nonempty_s, (state_q == TX_IDLE)};
            OFF_RXDATA: io_rdata_d = nonempty_s ? {24'b0, rx_mem_q[rd_ptr_q]} : 32'h0;
            OFF_CYCLE:  io_rdata_d = cycle_q;
            OFF_RETIRE: io_rdata_d = retired_q;
            default:    io_rdata_d = 32'h0;
         endcase
      end else begin
         io_rdata_d = io_rdata_q;
      end
   end

   // Counter clear takes priority over the increment in the same cycle.
   always_comb begin
      if (clear_s) begin
         cycle_d   = 32'h0;
         retired_d = 32'h0;
      end else begin
         cycle_d   = cycle_q + 32'd1;
         retired_d = retired_q + {31'b0, inst_retire};
      end
   end

   // TX next-state logic; a store arriving while in SEND is dropped.
   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      case (state_q)
         TX_IDLE: begin
            if (tx_start_s) begin
               state_d   = TX_SEND;
               tx_data_d = wdata[7:0];
            end else begin
               state_d = TX_IDLE;
            end
         end
         TX_SEND: begin
            if (uart.uart_tx_ready) begin
               state_d = TX_IDLE;
            end else begin
               state_d = TX_SEND;
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   // TX and RX handshake outputs are decoded from flops only.
   always_comb begin
      uart.uart_tx_valid = (state_q == TX_SEND);
      uart.uart_tx_data  = tx_data_q;
      uart.uart_rx_ready = (count_q != FULL);
      io_rdata           = io_rdata_q;
   end

   // All state registers.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= TX_IDLE;
         tx_data_q  <= 8'h0;
         io_rdata_q <= 32'h0;
         cycle_q    <= 32'h0;
         retired_q  <= 32'h0;
         wr_ptr_q   <= {PW{1'b0}};
         rd_ptr_q   <= {PW{1'b0}};
         count_q    <= {CW{1'b0}};
         for (int i = 0; i < RX_DEPTH; i++) begin
            rx_mem_q[i] <= 8'h0;
         end
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         io_rdata_q <= io_rdata_d;
         cycle_q    <= cycle_d;
         retired_q  <= retired_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         for (int i = 0; i < RX_DEPTH; i++) begin
            rx_mem_q[i] <= rx_mem_d[i];
         end
      end
   end

endmodule

// File: tb/tb_io_controller.sv
// Directed and randomized checks of io_controller.
// The expected values come from a queue-based reference model.
module tb_io_controller;
   localparam int DEPTH = 4;

   logic        Clock = 1'b0;
   logic        Reset_n;
   logic [31:0] addr, wdata, io_rdata;
   logic [3:0]  io_trans;
   logic        io_recv, haz_ena, inst_retire;

   io_controller_if uart_if ();

   io_controller #(.RX_DEPTH(DEPTH)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .addr(addr), .io_trans(io_trans),
      .io_recv(io_recv), .wdata(wdata), .haz_ena(haz_ena),
      .inst_retire(inst_retire), .io_rdata(io_rdata), .uart(uart_if.master)
   );

   always #5 Clock = ~Clock;

   // reference model state
   logic [31:0] m_cyc, m_ret, m_rdata;
   logic [7:0]  m_rxq [$];
   bit          m_busy;
   logic [7:0]  m_txb;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".io_rdata"}, io_rdata, m_rdata);
      check({tag, ".tx_valid"}, {31'b0, uart_if.uart_tx_valid}, m_busy ? 32'd1 : 32'd0);
      check({tag, ".tx_data"}, {24'b0, uart_if.uart_tx_data}, {24'b0, m_txb});
      check({tag, ".rx_ready"}, {31'b0, uart_if.uart_rx_ready}, (m_rxq.size() != DEPTH) ? 32'd1 : 32'd0);
   endtask

   task automatic model_reset();
      m_cyc = 32'h0; m_ret = 32'h0; m_rdata = 32'h0;
      m_busy = 1'b0; m_txb = 8'h0;
      m_rxq.delete();
   endtask

   task automatic idle_inputs();
      addr = 32'h0; wdata = 32'h0; io_trans = 4'h0; io_recv = 1'b0;
      haz_ena = 1'b1; inst_retire = 1'b0;
      uart_if.uart_tx_ready = 1'b0; uart_if.uart_rx_valid = 1'b0; uart_if.uart_rx_data = 8'h0;
   endtask

   // Advance the model by one cycle from the current inputs, then clock the DUT.
   task automatic tick();
      bit         sel, ld, st, push, pop;
      logic [7:0] off;
      logic [31:0] nr;
      sel  = (addr[31:28] == 4'h8);
      off  = addr[7:0];
      ld   = io_recv && haz_ena && sel;
      st   = (io_trans != 4'h0) && haz_ena && sel;
      nr   = m_rdata;
      pop  = 1'b0;
      push = uart_if.uart_rx_valid && (m_rxq.size() < DEPTH);
      if (ld) begin
         if (off == 8'h00)      nr = ((m_rxq.size() > 0) ? 32'd2 : 32'd0) + (m_busy ? 32'd0 : 32'd1);
         else if (off == 8'h04) begin
            nr  = (m_rxq.size() > 0) ? {24'b0, m_rxq[0]} : 32'h0;
            pop = (m_rxq.size() > 0);
         end
         else if (off == 8'h10) nr = m_cyc;
         else if (off == 8'h14) nr = m_ret;
         else                   nr = 32'h0;
      end
      if (m_busy) begin
         if (uart_if.uart_tx_ready) m_busy = 1'b0;
      end else if (st && off == 8'h08 && io_trans[0]) begin
         m_busy = 1'b1;
         m_txb  = wdata[7:0];
      end
      if (st && off == 8'h18) begin
         m_cyc = 32'h0; m_ret = 32'h0;
      end else begin
         m_cyc = m_cyc + 32'd1;
         m_ret = m_ret + (inst_retire ? 32'd1 : 32'd0);
      end
      if (pop)  void'(m_rxq.pop_front());
      if (push) m_rxq.push_back(uart_if.uart_rx_data);
      m_rdata = nr;
      @(posedge Clock);
      #1;
   endtask

   task automatic do_load(input logic [31:0] a, input string tag);
      addr = a; io_recv = 1'b1; io_trans = 4'h0;
      tick();
      io_recv = 1'b0;
      check_all(tag);
   endtask

   logic [31:0] addr_tbl [8] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_0010,
                                 32'h8000_0014, 32'h8000_0018, 32'h8000_000C, 32'h4000_0004};

   initial begin
      idle_inputs();
      model_reset();
      Reset_n = 1'b1;
      #1 Reset_n = 1'b0;
      #1;
      check("reset.io_rdata", io_rdata, 32'h0);
      check("reset.tx_valid", {31'b0, uart_if.uart_tx_valid}, 32'h0);
      check("reset.tx_data", {24'b0, uart_if.uart_tx_data}, 32'h0);
      check("reset.rx_ready", {31'b0, uart_if.uart_rx_ready}, 32'h1);
      @(posedge Clock); @(posedge Clock); #1;
      Reset_n = 1'b1;

      // idle 10 cycles, then read the cycle counter
      for (int i = 0; i < 10; i++) tick();
      do_load(32'h8000_0010, "cycle_after_10");
      check("cycle_is_10", io_rdata, 32'd10);
      do_load(32'h8000_0000, "status_idle");
      check("status_is_1", io_rdata, 32'h1);

      // TX with back-pressure; stores during SEND are dropped
      addr = 32'h8000_0008; wdata = 32'h0000_007a; io_trans = 4'b0001;
      tick();
      check_all("tx_start");
      check("tx_data_7a", {24'b0, uart_if.uart_tx_data}, 32'h7a);
      wdata = 32'h0000_0033;
      for (int i = 0; i < 2; i++) begin
         tick();
         check_all("tx_hold");
      end
      check("tx_still_7a", {24'b0, uart_if.uart_tx_data}, 32'h7a);
      uart_if.uart_tx_ready = 1'b1;
      tick();
      check_all("tx_done");
      check("tx_idle_after_hs", {31'b0, uart_if.uart_tx_valid}, 32'h0);
      io_trans = 4'h0; uart_if.uart_tx_ready = 1'b0;
      tick();
      check_all("tx_dropped");
      check("tx_no_requeue", {31'b0, uart_if.uart_tx_valid}, 32'h0);

      // fill RX FIFO, attempt overflow, then drain
      uart_if.uart_rx_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         uart_if.uart_rx_data = 8'h41 + 8'(i);
         tick();
         check_all("rx_fill");
      end
      check("rx_full_not_ready", {31'b0, uart_if.uart_rx_ready}, 32'h0);
      uart_if.uart_rx_data = 8'h45;
      tick();
      check_all("rx_overflow");
      uart_if.uart_rx_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         do_load(32'h8000_0004, "rx_drain");
         check("rx_drain_value", io_rdata, (i < 4) ? (32'h41 + 32'(i)) : 32'h0);
      end

      // push and load together on an empty FIFO
      uart_if.uart_rx_valid = 1'b1; uart_if.uart_rx_data = 8'h55;
      do_load(32'h8000_0004, "rx_empty_pushpop");
      check("rx_empty_load_zero", io_rdata, 32'h0);
      uart_if.uart_rx_valid = 1'b0;
      do_load(32'h8000_0004, "rx_after_push");
      check("rx_got_55", io_rdata, 32'h55);

      // counters: retire, clear, stalled clear
      addr = 32'h8000_0018; io_trans = 4'b0100;
      tick();
      io_trans = 4'h0; inst_retire = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      inst_retire = 1'b0;
      do_load(32'h8000_0014, "retired_5");
      check("retired_is_5", io_rdata, 32'd5);
      addr = 32'h8000_0018; io_trans = 4'b1000;
      tick();
      do_load(32'h8000_0010, "cycle_cleared");
      check("cycle_is_0", io_rdata, 32'h0);
      do_load(32'h8000_0014, "retired_cleared");
      check("retired_is_0", io_rdata, 32'h0);
      addr = 32'h8000_0018; io_trans = 4'b0001; haz_ena = 1'b0; inst_retire = 1'b1;
      tick();
      haz_ena = 1'b1; inst_retire = 1'b0;
      do_load(32'h8000_0014, "stalled_clear");
      check("retired_not_cleared", io_rdata, 32'd1);

      // reset in the middle of SEND with two bytes queued
      addr = 32'h8000_0008; wdata = 32'h0000_0011; io_trans = 4'b0001;
      uart_if.uart_rx_valid = 1'b1; uart_if.uart_rx_data = 8'h66;
      tick();
      io_trans = 4'h0; uart_if.uart_rx_data = 8'h67;
      tick();
      uart_if.uart_rx_valid = 1'b0;
      check_all("pre_reset");
      Reset_n = 1'b0;
      #2;
      check("async_rst.tx_valid", {31'b0, uart_if.uart_tx_valid}, 32'h0);
      check("async_rst.rx_ready", {31'b0, uart_if.uart_rx_ready}, 32'h1);
      check("async_rst.io_rdata", io_rdata, 32'h0);
      model_reset();
      Reset_n = 1'b1;
      do_load(32'h8000_0000, "status_after_reset");
      check("status_after_reset_1", io_rdata, 32'h1);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         addr        = addr_tbl[$urandom_range(0, 7)];
         wdata       = $urandom;
         io_recv     = ($urandom_range(0, 1) == 1);
         io_trans    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         if (addr[7:0] == 8'h18 && $urandom_range(0, 7) != 0) io_trans = 4'h0;
         haz_ena     = ($urandom_range(0, 3) != 0);
         inst_retire = ($urandom_range(0, 1) == 1);
         uart_if.uart_tx_ready = ($urandom_range(0, 2) == 0);
         uart_if.uart_rx_valid = ($urandom_range(0, 1) == 1);
         uart_if.uart_rx_data  = 8'($urandom);
         tick();
         check_all("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
